// File: rtl/rmon_stat_updater.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rmon_stat_updater                                                        |
// | RMON counter read-modify-write engine and clear sweep on RAM port-a.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module rmon_stat_updater #(
   parameter int BANK_W  = 16,
   parameter int RX_BASE = 0,
   parameter int TX_BASE = 32,
   parameter int AW      = 6,
   parameter int DW      = 32
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Rx_req,
   input  logic [BANK_W-1:0] Rx_inc_vec,
   input  logic [15:0]       Rx_len,
   output logic              Rx_ack,
   input  logic              Tx_req,
   input  logic [BANK_W-1:0] Tx_inc_vec,
   input  logic [15:0]       Tx_len,
   output logic              Tx_ack,
   input  logic              Clr_req,
   output logic              Clr_busy,
   output logic [AW-1:0]     Addra,
   output logic [DW-1:0]     Dina,
   input  logic [DW-1:0]     Douta,
   output logic              Wea
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD   = 3'd1,
      S_WR   = 3'd2,
      S_DONE = 3'd3,
      S_CLR  = 3'd4
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic              r_src_tx;
   logic              r_rr_tx;
   logic              r_clr_pend;
   logic [BANK_W-1:0] r_vec;
   logic [15:0]       r_len;
   logic [AW-1:0]     r_clr_addr;

   logic              w_clr_go;
   logic              w_grant;
   logic              w_grant_tx;
   logic [BANK_W-1:0] w_req_vec;
   logic [BANK_W-1:0] w_vec_rem;
   logic [AW-1:0]     w_idx;
   logic [AW-1:0]     w_base;

   // Round-robin: Tx wins a tie only when the pointer favours it.
   assign w_clr_go   = r_clr_pend || Clr_req;
   assign w_grant    = Rx_req || Tx_req;
   assign w_grant_tx = Tx_req && (!Rx_req || r_rr_tx);
   assign w_req_vec  = w_grant_tx ? Tx_inc_vec : Rx_inc_vec;
   assign w_vec_rem  = r_vec & (r_vec - BANK_W'(1));
   assign w_base     = r_src_tx ? AW'(TX_BASE) : AW'(RX_BASE);

   always_comb begin
      w_idx = '0;
      for (int i = BANK_W - 1; i >= 0; i--) begin
         if (r_vec[i]) w_idx = AW'(i);
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next   = r_state;
      Addra    = '0;
      Dina     = '0;
      Wea      = 1'b0;
      Rx_ack   = 1'b0;
      Tx_ack   = 1'b0;
      Clr_busy = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_clr_go)     w_next = S_CLR;
            else if (w_grant) w_next = (w_req_vec != '0) ? S_RD : S_DONE;
         end
         S_RD: begin
            Addra  = w_base + w_idx;
            w_next = S_WR;
         end
         S_WR: begin
            // Bit 0 is the octet counter; every other counter is a plain event count.
            Addra  = w_base + w_idx;
            Wea    = 1'b1;
            Dina   = Douta + (r_vec[0] ? DW'(r_len) : DW'(1));
            w_next = (w_vec_rem != '0) ? S_RD : S_DONE;
         end
         S_DONE: begin
            Rx_ack = !r_src_tx;
            Tx_ack = r_src_tx;
            w_next = S_IDLE;
         end
         S_CLR: begin
            Addra    = r_clr_addr;
            Wea      = 1'b1;
            Clr_busy = 1'b1;
            if (r_clr_addr == '1) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_src_tx   <= 1'b0;
         r_rr_tx    <= 1'b0;
         r_clr_pend <= 1'b0;
         r_vec      <= '0;
         r_len      <= '0;
         r_clr_addr <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_clr_go) begin
                  r_clr_pend <= 1'b0;
                  r_clr_addr <= '0;
               end else if (w_grant) begin
                  r_src_tx <= w_grant_tx;
                  r_rr_tx  <= !w_grant_tx;
                  r_vec    <= w_req_vec;
                  r_len    <= w_grant_tx ? Tx_len : Rx_len;
               end
            end
            S_RD: begin
               if (Clr_req) r_clr_pend <= 1'b1;
            end
            S_WR: begin
               r_vec <= w_vec_rem;
               if (Clr_req) r_clr_pend <= 1'b1;
            end
            S_DONE: begin
               if (Clr_req) r_clr_pend <= 1'b1;
            end
            S_CLR: begin
               r_clr_addr <= r_clr_addr + AW'(1);
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_rmon_stat_updater.sv
`default_nettype none
// Randomized bench for rmon_stat_updater: models the RAM and keeps a reference counter image.
module tb_rmon_stat_updater;
   localparam int BANK_W  = 16;
   localparam int RX_BASE = 0;
   localparam int TX_BASE = 32;
   localparam int AW      = 6;
   localparam int DW      = 32;
   localparam int NW      = 1 << AW;

   logic              Clk = 1'b0;
   logic              Reset = 1'b0;
   logic              Rx_req = 1'b0;
   logic [BANK_W-1:0] Rx_inc_vec = '0;
   logic [15:0]       Rx_len = '0;
   logic              Rx_ack;
   logic              Tx_req = 1'b0;
   logic [BANK_W-1:0] Tx_inc_vec = '0;
   logic [15:0]       Tx_len = '0;
   logic              Tx_ack;
   logic              Clr_req = 1'b0;
   logic              Clr_busy;
   logic [AW-1:0]     Addra;
   logic [DW-1:0]     Dina;
   logic [DW-1:0]     Douta;
   logic              Wea;

   logic              pl_we = 1'b0;
   logic [AW-1:0]     pl_addr = '0;
   logic [DW-1:0]     pl_data = '0;
   logic [DW-1:0]     mem [0:NW-1];
   logic [DW-1:0]     ref_mem [0:NW-1];

   int                n_chk = 0;
   int                n_err = 0;
   int                busy_cnt = 0;
   bit                favour_tx = 1'b0;
   logic [AW+DW-1:0]  wr_q [$];
   logic [AW+DW-1:0]  exp_q [$];

   rmon_stat_updater #(
      .BANK_W(BANK_W), .RX_BASE(RX_BASE), .TX_BASE(TX_BASE), .AW(AW), .DW(DW)
   ) u_dut (
      .Clk(Clk), .Reset(Reset),
      .Rx_req(Rx_req), .Rx_inc_vec(Rx_inc_vec), .Rx_len(Rx_len), .Rx_ack(Rx_ack),
      .Tx_req(Tx_req), .Tx_inc_vec(Tx_inc_vec), .Tx_len(Tx_len), .Tx_ack(Tx_ack),
      .Clr_req(Clr_req), .Clr_busy(Clr_busy),
      .Addra(Addra), .Dina(Dina), .Douta(Douta), .Wea(Wea)
   );

   always #5 Clk = ~Clk;

   // RAM with 1-cycle read latency; pl_* stands in for the CPU port.
   always @(posedge Clk) begin
      if (Wea) mem[Addra] <= Dina;
      else if (pl_we) mem[pl_addr] <= pl_data;
      Douta <= mem[Addra];
   end

   always @(negedge Clk) begin
      if (Reset && Wea === 1'b1) wr_q.push_back({Addra, Dina});
      if (Clr_busy === 1'b1) busy_cnt++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input bit tx, input bit r, input logic [BANK_W-1:0] v, input logic [15:0] len);
      if (tx) begin Tx_req = r; Tx_inc_vec = v; Tx_len = len; end
      else    begin Rx_req = r; Rx_inc_vec = v; Rx_len = len; end
   endtask

   // Reference: each set bit bumps its counter, ascending order; bit 0 adds the length.
   task automatic model_update(input bit tx, input logic [BANK_W-1:0] v, input logic [15:0] len);
      int base;
      base = tx ? TX_BASE : RX_BASE;
      for (int i = 0; i < BANK_W; i++) begin
         if (v[i]) begin
            ref_mem[base+i] = ref_mem[base+i] + ((i == 0) ? DW'(len) : DW'(1));
            exp_q.push_back({AW'(base+i), ref_mem[base+i]});
         end
      end
      favour_tx = !tx;
   endtask

   task automatic model_clear();
      for (int a = 0; a < NW; a++) begin
         ref_mem[a] = '0;
         exp_q.push_back({AW'(a), DW'(0)});
      end
   endtask

   task automatic preload(input int a, input logic [DW-1:0] d);
      @(posedge Clk); #1;
      pl_we = 1'b1; pl_addr = AW'(a); pl_data = d;
      @(posedge Clk); #1;
      pl_we = 1'b0;
      ref_mem[a] = d;
   endtask

   task automatic wait_ack(input bit tx, input int budget, output int cyc);
      cyc = 0;
      forever begin
         @(negedge Clk);
         cyc++;
         if ((tx ? Rx_ack : Tx_ack) === 1'b1) chk("wrong_ack", 1, 0);
         if ((tx ? Tx_ack : Rx_ack) === 1'b1) break;
         if (cyc >= budget) begin
            chk("ack_timeout", 0, 1);
            cyc = -1;
            break;
         end
      end
   endtask

   task automatic cmp_writes(input string tag);
      chk({tag, "_nwr"}, wr_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
         chk({tag, "_wr"}, wr_q[i], exp_q[i]);
   endtask

   task automatic cmp_mem(input string tag);
      for (int a = 0; a < NW; a++) chk({tag, "_mem"}, mem[a], ref_mem[a]);
   endtask

   task automatic drop_and_check(input bit tx, input string tag);
      @(posedge Clk); #1;
      set_req(tx, 1'b0, '0, '0);
      @(negedge Clk);
      chk({tag, "_ackpulse"}, tx ? Tx_ack : Rx_ack, 0);
   endtask

   task automatic do_single(input bit tx, input logic [BANK_W-1:0] v, input logic [15:0] len, input string tag);
      int cyc, n;
      wr_q.delete(); exp_q.delete();
      n = $countones(v);
      model_update(tx, v, len);
      @(posedge Clk); #1;
      set_req(tx, 1'b1, v, len);
      @(posedge Clk);
      wait_ack(tx, 2 * BANK_W + 8, cyc);
      chk({tag, "_lat"}, cyc, 2 * n + 1);
      drop_and_check(tx, tag);
      cmp_writes(tag);
      cmp_mem(tag);
   endtask

   task automatic do_pair(input logic [BANK_W-1:0] vrx, input logic [15:0] lrx,
                          input logic [BANK_W-1:0] vtx, input logic [15:0] ltx, input string tag);
      bit first_tx;
      int cyc;
      first_tx = favour_tx;
      wr_q.delete(); exp_q.delete();
      model_update(first_tx, first_tx ? vtx : vrx, first_tx ? ltx : lrx);
      model_update(!first_tx, first_tx ? vrx : vtx, first_tx ? lrx : ltx);
      @(posedge Clk); #1;
      set_req(1'b0, 1'b1, vrx, lrx);
      set_req(1'b1, 1'b1, vtx, ltx);
      @(posedge Clk);
      wait_ack(first_tx, 2 * BANK_W + 8, cyc);
      chk({tag, "_lat1"}, cyc, 2 * $countones(first_tx ? vtx : vrx) + 1);
      @(posedge Clk); #1;
      set_req(first_tx, 1'b0, '0, '0);
      wait_ack(!first_tx, 2 * BANK_W + 8, cyc);
      chk({tag, "_lat2"}, cyc, 2 * $countones(first_tx ? vrx : vtx) + 2);
      drop_and_check(!first_tx, tag);
      cmp_writes(tag);
      cmp_mem(tag);
   endtask

   task automatic do_clear(input string tag);
      int k;
      wr_q.delete(); exp_q.delete();
      model_clear();
      busy_cnt = 0;
      @(posedge Clk); #1;
      Clr_req = 1'b1;
      @(posedge Clk); #1;
      Clr_req = 1'b0;
      k = 0;
      do begin
         @(negedge Clk);
         k++;
      end while (!(busy_cnt > 0 && Clr_busy === 1'b0) && k < 200);
      chk({tag, "_busy"}, busy_cnt, NW);
      cmp_writes(tag);
      cmp_mem(tag);
   endtask

   // Clear requested while an Rx update is in flight and Tx is waiting.
   task automatic do_clr_mid(input logic [BANK_W-1:0] vrx, input logic [15:0] lrx,
                             input logic [BANK_W-1:0] vtx, input logic [15:0] ltx, input string tag);
      int cyc;
      wr_q.delete(); exp_q.delete();
      model_update(1'b0, vrx, lrx);
      model_clear();
      model_update(1'b1, vtx, ltx);
      busy_cnt = 0;
      @(posedge Clk); #1;
      set_req(1'b0, 1'b1, vrx, lrx);
      @(posedge Clk); #1;
      set_req(1'b1, 1'b1, vtx, ltx);
      Clr_req = 1'b1;
      @(posedge Clk); #1;
      Clr_req = 1'b0;
      wait_ack(1'b0, 2 * BANK_W + 8, cyc);
      chk({tag, "_rxlat"}, cyc, 2 * $countones(vrx));
      @(posedge Clk); #1;
      set_req(1'b0, 1'b0, '0, '0);
      wait_ack(1'b1, 2 * BANK_W + NW + 40, cyc);
      chk({tag, "_txlat"}, cyc, 2 * $countones(vtx) + NW + 3);
      chk({tag, "_busy"}, busy_cnt, NW);
      drop_and_check(1'b1, tag);
      cmp_writes(tag);
      cmp_mem(tag);
   endtask

   task automatic reset_mid_wr();
      int k, seen;
      wr_q.delete(); exp_q.delete();
      @(posedge Clk); #1;
      set_req(1'b0, 1'b1, 16'h0013, 16'd5);
      @(posedge Clk);
      k = 0; seen = 0;
      while (seen < 2 && k < 20) begin
         @(negedge Clk);
         k++;
         if (Wea === 1'b1) seen++;
      end
      chk("t6_wr_reached", seen, 2);
      Reset = 1'b0;
      set_req(1'b0, 1'b0, '0, '0);
      #1;
      chk("t6_out_now", {Rx_ack, Tx_ack, Clr_busy, Wea, Addra, Dina}, 0);
      @(negedge Clk);
      chk("t6_out_next", {Rx_ack, Tx_ack, Clr_busy, Wea, Addra, Dina}, 0);
      @(negedge Clk);
      Reset = 1'b1;
      // Only the bit-0 write completed before reset hit.
      ref_mem[RX_BASE] = ref_mem[RX_BASE] + DW'(5);
      favour_tx = 1'b0;
      wr_q.delete();
      cmp_mem("t6");
   endtask

   function automatic logic [BANK_W-1:0] rnd_vec();
      case ($urandom_range(0, 3))
         0:       return '0;
         1:       return '1;
         default: return BANK_W'($urandom);
      endcase
   endfunction

   task automatic random_round(input int iters);
      logic [BANK_W-1:0] va, vb;
      for (int it = 0; it < iters; it++) begin
         va = rnd_vec();
         vb = rnd_vec();
         if ($urandom_range(0, 2) == 0)
            preload($urandom_range(0, NW - 1), (($urandom_range(0, 1) == 0) ? 32'hFFFF_FFF0 : 32'h0) | $urandom_range(0, 15));
         case ($urandom_range(0, 7))
            0, 1, 2: do_single(1'b0, va, 16'($urandom), "rnd_rx");
            3, 4:    do_single(1'b1, va, 16'($urandom), "rnd_tx");
            5, 6:    do_pair(va, 16'($urandom), vb, 16'($urandom), "rnd_pair");
            default: do_clr_mid(va | BANK_W'(1 << $urandom_range(0, BANK_W - 1)), 16'($urandom),
                                vb, 16'($urandom), "rnd_clr");
         endcase
      end
   endtask

   initial begin
      for (int a = 0; a < NW; a++) ref_mem[a] = '0;
      @(negedge Clk);
      @(negedge Clk);
      chk("reset_out", {Rx_ack, Tx_ack, Clr_busy, Wea, Addra, Dina}, 0);
      Reset = 1'b1;
      do_clear("init_clr");
      do_pair(16'h0003, 16'd10, 16'h0005, 16'd20, "t4a");
      do_pair(16'h0010, 16'd1, 16'h0001, 16'd7, "t4b");
      preload(RX_BASE, 32'd100);
      do_single(1'b0, 16'h0001, 16'd64, "t1");
      do_single(1'b0, 16'h8006, 16'd0, "t2");
      preload(TX_BASE + 3, 32'hFFFF_FFFF);
      do_single(1'b1, 16'h0008, 16'd0, "t3");
      preload(TX_BASE, 32'hFFFF_FFF0);
      do_single(1'b1, 16'h0001, 16'h0020, "t3_len_wrap");
      do_clr_mid(16'h0105, 16'd33, 16'h0003, 16'd12, "t5");
      random_round(30);
      reset_mid_wr();
      do_single(1'b0, 16'h0000, 16'd99, "t6_vec0");
      do_pair(16'h0002, 16'd0, 16'h0004, 16'd0, "t6_rr");
      random_round(15);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
